// File: rtl/game_round_ctrl_pkg.sv
// Shared definitions for the guessing-game round controller: state encoding,
// target-generator taps and seed, and the LFSR step function.
package game_round_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_GUESS = 3'd2,
    CHECK      = 3'd3,
    RESULT     = 3'd4,
    DONE       = 3'd5
  } state_t;

  // Feedback taps on bits 3 and 2; the feedback bit enters at bit 0.
  localparam logic [3:0] LFSR_TAPS         = 4'b1100;
  localparam logic [3:0] LFSR_DEFAULT_SEED = 4'b1001;

  function automatic logic [3:0] lfsr_next(input logic [3:0] cur);
    return {cur[2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/salidzinatajs.sv
// 4-bit equality comparator used to judge the latched guess against the target.
module salidzinatajs (
  input  logic [3:0] num_1,
  input  logic [3:0] num_2,
  output logic       match
);

  assign match = (num_1 == num_2);

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller for a number-guessing game: draws a target per round from
// an LFSR, waits for a guess with timeout, scores hits and signals the outcome.
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         ROUNDS         = 8,
  parameter logic [3:0] LFSR_SEED      = LFSR_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] guess,
  input  logic       submit,
  output logic [3:0] target,
  output logic [3:0] score,
  output logic [2:0] round_idx,
  output logic       busy,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       done
);

  localparam int                 TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         LAST_ROUND = 3'(ROUNDS - 1);

  state_t             state;
  logic [3:0]         lfsr;
  logic [3:0]         guess_q;
  logic [TIMER_W-1:0] timer;
  logic               match;

  salidzinatajs u_cmp (
    .num_1 (guess_q),
    .num_2 (target),
    .match (match)
  );

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      target     <= '0;
      score      <= '0;
      round_idx  <= '0;
      timer      <= '0;
      guess_q    <= '0;
      busy       <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: pulses default low each cycle and are set only on the edge that
      // enters RESULT, which makes them exactly one cycle wide.
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            score     <= '0;
            round_idx <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= LOAD;
          end
        end

        LOAD: begin
          target <= lfsr;
          lfsr   <= lfsr_next(lfsr);
          timer  <= TIMER_LOAD;
          state  <= WAIT_GUESS;
        end

        WAIT_GUESS: begin
          if (timer != '0) begin
            timer <= timer - TIMER_W'(1);
          end
          // A guess arriving on the expiry cycle still counts.
          if (submit) begin
            guess_q <= guess;
            state   <= CHECK;
          end else if (timer == '0) begin
            miss_pulse <= 1'b1;
            state      <= RESULT;
          end
        end

        CHECK: begin
          if (match) begin
            if (score != 4'hF) begin
              score <= score + 4'd1;
            end
            hit_pulse <= 1'b1;
          end else begin
            miss_pulse <= 1'b1;
          end
          state <= RESULT;
        end

        RESULT: begin
          if (round_idx == LAST_ROUND) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            round_idx <= round_idx + 3'd1;
            state     <= LOAD;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
